// File: rtl/ddr4_cmd_gen.sv
// ddr4_cmd_gen: single-rank DDR4 command sequencer with an open-row table.
//
// Accepts one read/write request at a time and issues the command sequence
// PRE -> ACT -> RD/WR as needed. The sequence depends on whether the
// target bank is closed, open on the same row, or open on another row.
// Each command lasts one cycle. DES is driven in every other cycle.
//
// Ports:
//   ck2x        in   sole clock, all logic on posedge
//   reset_n     in   synchronous active-low reset
//   req_valid   in   request valid
//   req_ready   out  request accepted when req_valid && req_ready
//   req_wr      in   1 = write, 0 = read
//   req_bg      in   bank group
//   req_ba      in   bank within group
//   req_row     in   row address
//   req_col     in   column address
//   stall       in   DIMM back-pressure; holds PRE/ACT/CAS and drives DES
//   cke         out  clock enable, rises the first cycle after reset release
//   cs_n        out  chip select
//   act_n       out  activate
//   A           out  row (ACT) or {ras_n,cas_n,we_n} in A[16:14] plus column
//   bg, ba      out  bank group / bank of the current command
//   cas_issued  out  one-cycle pulse on every RD/WR issue
//
// Optional feature: define AUTO_PRECHARGE_EN to issue RDA/WRA (A10=1).
// Each access then closes its bank, so every access takes the ACT path.
// A must be at least 17 bits wide and COLWIDTH at most 10.
module ddr4_cmd_gen #(
    parameter int unsigned BGWIDTH   = 2,
    parameter int unsigned BAWIDTH   = 2,
    parameter int unsigned ADDRWIDTH = 17,
    parameter int unsigned COLWIDTH  = 10,
    parameter int unsigned TRP       = 4,
    parameter int unsigned TRCD      = 4,
    parameter int unsigned TCCD      = 4
) (
    input  logic                 ck2x,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    input  logic                 stall,
    output logic                 cke,
    output logic                 cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic                 cas_issued
);

    localparam int unsigned BKWIDTH = BGWIDTH + BAWIDTH;
    localparam int unsigned NBANK   = 1 << BKWIDTH;

    localparam logic [3:0] RP_WAIT  = 4'(TRP - 1);
    localparam logic [3:0] RCD_WAIT = 4'(TRCD - 1);

    // The CAS cycle, WAIT_CCD and the IDLE accept cycle together span TCCD.
    // Back-to-back row hits therefore issue exactly TCCD cycles apart.
`ifdef AUTO_PRECHARGE_EN
    localparam int   CCD_RAW = int'(TCCD) + int'(TRP) - 2;
    localparam logic CAS_A10 = 1'b1;
`else
    localparam int   CCD_RAW = int'(TCCD) - 2;
    localparam logic CAS_A10 = 1'b0;
`endif
    localparam int         CCD_SAT  = (CCD_RAW < 0) ? 0 : ((CCD_RAW > 15) ? 15 : CCD_RAW);
    localparam logic [3:0] CCD_WAIT = 4'(CCD_SAT);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_RP,
        ACT,
        WAIT_RCD,
        CAS,
        WAIT_CCD
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [3:0]             r_cnt, w_cnt_nxt;
    logic                   r_cke;
    logic                   r_rdy_en;
    logic                   r_wr;
    logic [BGWIDTH-1:0]     r_bg;
    logic [BAWIDTH-1:0]     r_ba;
    logic [ADDRWIDTH-1:0]   r_row;
    logic [COLWIDTH-1:0]    r_col;
    logic [NBANK-1:0]       r_valid;
    logic [ADDRWIDTH-1:0]   r_rows [NBANK];

    logic [BKWIDTH-1:0]     w_req_bank;
    logic [BKWIDTH-1:0]     w_lat_bank;
    logic                   w_accept;
    logic                   w_set;
    logic                   w_clr;

    assign w_req_bank = {req_bg, req_ba};
    assign w_lat_bank = {r_bg, r_ba};
    assign cke        = r_cke;

    always_ff @(posedge ck2x) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_cke    <= 1'b0;
            r_rdy_en <= 1'b0;
            r_valid  <= '0;
            r_wr     <= 1'b0;
            r_bg     <= '0;
            r_ba     <= '0;
            r_row    <= '0;
            r_col    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_cke    <= 1'b1;
            // Requests are allowed one cycle after cke rises.
            r_rdy_en <= r_cke;
            if (w_accept) begin
                r_wr  <= req_wr;
                r_bg  <= req_bg;
                r_ba  <= req_ba;
                r_row <= req_row;
                r_col <= req_col;
            end
            if (w_set) begin
                r_valid[w_lat_bank] <= 1'b1;
            end else if (w_clr) begin
                r_valid[w_lat_bank] <= 1'b0;
            end
        end
    end

    // Row storage needs no reset; the valid bits qualify every lookup.
    always_ff @(posedge ck2x) begin
        if (w_set) begin
            r_rows[w_lat_bank] <= r_row;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_set       = 1'b0;
        w_clr       = 1'b0;
        req_ready   = 1'b0;
        cs_n        = 1'b1;
        act_n       = 1'b1;
        A           = '0;
        bg          = '0;
        ba          = '0;
        cas_issued  = 1'b0;

        unique case (r_state)
            IDLE: begin
                req_ready = r_rdy_en && !stall;
                if (req_valid && req_ready) begin
                    w_accept = 1'b1;
                    if (r_valid[w_req_bank] && (r_rows[w_req_bank] == req_row)) begin
                        w_state_nxt = CAS;
                    end else if (r_valid[w_req_bank]) begin
                        w_state_nxt = PRE;
                    end else begin
                        w_state_nxt = ACT;
                    end
                end
            end
            PRE: begin
                if (!stall) begin
                    cs_n      = 1'b0;
                    A[16:14]  = 3'b010;
                    bg        = r_bg;
                    ba        = r_ba;
                    w_clr     = 1'b1;
                    if (RP_WAIT == 4'd0) begin
                        w_state_nxt = ACT;
                    end else begin
                        w_state_nxt = WAIT_RP;
                        w_cnt_nxt   = RP_WAIT;
                    end
                end
            end
            WAIT_RP: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = ACT;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ACT: begin
                if (!stall) begin
                    cs_n  = 1'b0;
                    act_n = 1'b0;
                    A     = r_row;
                    bg    = r_bg;
                    ba    = r_ba;
                    w_set = 1'b1;
                    if (RCD_WAIT == 4'd0) begin
                        w_state_nxt = CAS;
                    end else begin
                        w_state_nxt = WAIT_RCD;
                        w_cnt_nxt   = RCD_WAIT;
                    end
                end
            end
            WAIT_RCD: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = CAS;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            CAS: begin
                if (!stall) begin
                    cs_n                = 1'b0;
                    A[16:14]            = r_wr ? 3'b100 : 3'b101;
                    A[COLWIDTH-1:0]     = r_col;
                    A[10]               = CAS_A10;
                    bg                  = r_bg;
                    ba                  = r_ba;
                    cas_issued          = 1'b1;
`ifdef AUTO_PRECHARGE_EN
                    w_clr               = 1'b1;
`endif
                    if (CCD_WAIT == 4'd0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = WAIT_CCD;
                        w_cnt_nxt   = CCD_WAIT;
                    end
                end
            end
            WAIT_CCD: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ddr4_cmd_gen.sv
// Directed bench for ddr4_cmd_gen (default build, TRP=TRCD=TCCD=4).
// Expected commands come from a small open-row model and are queued with their
// cycle numbers. A negedge monitor pops each entry when the DUT issues a
// command and checks that every other cycle is DES.
module tb_ddr4_cmd_gen;

    localparam int TRP  = 4;
    localparam int TRCD = 4;
    localparam int TCCD = 4;

    logic        ck2x      = 1'b0;
    logic        reset_n   = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wr    = 1'b0;
    logic [1:0]  req_bg    = '0;
    logic [1:0]  req_ba    = '0;
    logic [16:0] req_row   = '0;
    logic [9:0]  req_col   = '0;
    logic        stall     = 1'b0;
    logic        req_ready;
    logic        cke;
    logic        cs_n;
    logic        act_n;
    logic [16:0] A;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic        cas_issued;

    ddr4_cmd_gen dut (
        .ck2x       (ck2x),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_bg     (req_bg),
        .req_ba     (req_ba),
        .req_row    (req_row),
        .req_col    (req_col),
        .stall      (stall),
        .cke        (cke),
        .cs_n       (cs_n),
        .act_n      (act_n),
        .A          (A),
        .bg         (bg),
        .ba         (ba),
        .cas_issued (cas_issued)
    );

    always #5 ck2x = ~ck2x;

    int cyc = 0;
    always @(posedge ck2x) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic        act_n;
        logic [16:0] a;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic        cas;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    int          cas_log[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    bit          m_valid[16];
    logic [16:0] m_row[16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input int c, input logic an, input logic [16:0] a,
                            input logic [1:0] g, input logic [1:0] b, input logic cas);
        exp_t e;
        e.c     = c;
        e.act_n = an;
        e.a     = a;
        e.bg    = g;
        e.ba    = b;
        e.cas   = cas;
        sb.push_back(e);
    endtask

    always @(negedge ck2x) begin
        if (mon_en) begin
            if (cs_n === 1'b0) begin
                if (cas_issued === 1'b1) cas_log.push_back(cyc);
                check("cmd_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e_mon = sb.pop_front();
                    check("cmd_cycle", 32'(cyc), 32'(e_mon.c));
                    check("cmd_act_n", 32'(act_n), 32'(e_mon.act_n));
                    check("cmd_A", 32'(A), 32'(e_mon.a));
                    check("cmd_bg", 32'(bg), 32'(e_mon.bg));
                    check("cmd_ba", 32'(ba), 32'(e_mon.ba));
                    check("cmd_cas", 32'(cas_issued), 32'(e_mon.cas));
                end
            end else begin
                check("des_act_n", 32'(act_n), 32'd1);
                check("des_A", 32'(A), 32'd0);
                check("des_cas", 32'(cas_issued), 32'd0);
            end
        end
    end

    // Drive one request and queue the commands the model predicts for it.
    // s = cycles of stall applied right after acceptance (ACT slot on a closed bank).
    task automatic send(input logic wr, input logic [1:0] g, input logic [1:0] b,
                        input logic [16:0] row, input logic [9:0] col, input int s);
        int          n;
        int          bank;
        bit          ok;
        logic [16:0] cas_a;
        @(posedge ck2x);
        #1;
        req_wr    = wr;
        req_bg    = g;
        req_ba    = b;
        req_row   = row;
        req_col   = col;
        req_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ck2x);
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_in_time", 32'(ok), 32'd1);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        n     = cyc;
        bank  = int'({g, b});
        cas_a = (wr ? 17'h10000 : 17'h14000) | {7'b0, col};
        if (m_valid[bank] && m_row[bank] == row) begin
            push_cmd(n + 1, 1'b1, cas_a, g, b, 1'b1);
        end else if (m_valid[bank]) begin
            push_cmd(n + 1, 1'b1, 17'h08000, g, b, 1'b0);
            push_cmd(n + 1 + TRP, 1'b0, row, g, b, 1'b0);
            push_cmd(n + 1 + TRP + TRCD, 1'b1, cas_a, g, b, 1'b1);
        end else begin
            push_cmd(n + 1 + s, 1'b0, row, g, b, 1'b0);
            push_cmd(n + 1 + s + TRCD, 1'b1, cas_a, g, b, 1'b1);
        end
        m_valid[bank] = 1'b1;
        m_row[bank]   = row;
        @(posedge ck2x);
        #1;
        req_valid = 1'b0;
        if (s > 0) begin
            stall = 1'b1;
            for (int i = 0; i < s; i++) begin
                @(negedge ck2x);
                check("stall_ready_low", 32'(req_ready), 32'd0);
                @(posedge ck2x);
                #1;
            end
            stall = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge ck2x);
        @(negedge ck2x);
        check("queue_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cke"}, 32'(cke), 32'd0);
        check({tag, "_cs_n"}, 32'(cs_n), 32'd1);
        check({tag, "_act_n"}, 32'(act_n), 32'd1);
        check({tag, "_A"}, 32'(A), 32'd0);
        check({tag, "_bg"}, 32'(bg), 32'd0);
        check({tag, "_ba"}, 32'(ba), 32'd0);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_cas"}, 32'(cas_issued), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ncas;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;

        // Reset and cke/req_ready release timing
        repeat (3) @(posedge ck2x);
        mon_en = 1'b1;
        @(negedge ck2x);
        check_reset_outputs("rst");
        @(posedge ck2x);
        #1;
        reset_n = 1'b1;
        @(negedge ck2x);
        check("cke_before_sample", 32'(cke), 32'd0);
        @(negedge ck2x);
        check("cke_rise", 32'(cke), 32'd1);
        check("ready_after_cke", 32'(req_ready), 32'd0);
        @(negedge ck2x);
        check("ready_allowed", 32'(req_ready), 32'd1);

        // Closed bank read: ACT at N+1, RD at N+5, one cas pulse
        send(1'b0, 2'd1, 2'd2, 17'h00123, 10'h040, 0);
        drain();
        check("s1_cas_pulses", 32'(cas_log.size()), 32'd1);

        // Back-to-back row hits, read then write, spaced TCCD
        send(1'b0, 2'd1, 2'd2, 17'h00123, 10'h041, 0);
        send(1'b1, 2'd1, 2'd2, 17'h00123, 10'h042, 0);
        drain();
        check("hit_spacing", 32'(cas_log[2] - cas_log[1]), 32'(TCCD));

        // Row conflict: PRE, ACT after TRP, RD after TRCD
        send(1'b0, 2'd0, 2'd1, 17'h00010, 10'h005, 0);
        send(1'b0, 2'd0, 2'd1, 17'h00020, 10'h006, 0);
        drain();

        // Stall for three cycles at the ACT slot
        send(1'b0, 2'd2, 2'd0, 17'h00077, 10'h003, 3);
        drain();

        // Reset in WAIT_RCD aborts the RD and clears the open-row table
        send(1'b0, 2'd3, 2'd3, 17'h00055, 10'h007, 0);
        void'(sb.pop_back());
        ncas = cas_log.size();
        @(posedge ck2x);
        #1;
        reset_n = 1'b0;
        @(posedge ck2x);
        #1;
        @(negedge ck2x);
        check_reset_outputs("midrst");
        @(posedge ck2x);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        repeat (6) @(negedge ck2x);
        check("no_rd_after_reset", 32'(cas_log.size()), 32'(ncas));
        send(1'b0, 2'd3, 2'd3, 17'h00055, 10'h007, 0);
        drain();

        check("final_queue_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
